// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and helpers for the sequential
// binary-to-BCD converter.
package bcd_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam logic [3:0]  ADJ_THRESH = 4'd5;
    localparam logic [3:0]  ADJ_VAL    = 4'd3;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Ceiling log2, used to size the shift counter.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned rem;
        result = 0;
        rem    = (value > 0) ? value - 1 : 0;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more,
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] adjusted
);

    // Conditional +3 correction.
    always_comb begin
        adjusted = digit;
        if (digit >= ADJ_THRESH) begin
            adjusted = digit + ADJ_VAL;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter (shift-and-add-3), one input bit per
// clock, with start/busy/done handshake and overflow detection.
// Optional leading-zero blanking is enabled by defining BIN2BCD_BLANK_EN;
// otherwise blank_mask is tied low.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 10,
    parameter int unsigned DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [BIN_W-1:0]          bin_in,
    output logic                      busy,
    output logic                      done,
    output logic [DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                      overflow,
    output logic [DIGITS-1:0]         blank_mask
);

    localparam int unsigned BCD_W = DIGIT_W * DIGITS;
    localparam int unsigned CNT_W = clog2(BIN_W + 1);
    localparam int unsigned SH_W  = BCD_W + BIN_W + 1;

    state_t             state;
    state_t             state_nxt;
    logic [BIN_W-1:0]   bin_sr;
    logic [BCD_W-1:0]   bcd_sr;
    logic [CNT_W-1:0]   count;
    logic               ovf_sticky;

    logic [BCD_W-1:0]   bcd_adj;
    logic [SH_W-1:0]    shifted;
    logic [BCD_W-1:0]   bcd_nxt;
    logic [BIN_W-1:0]   bin_nxt;
    logic               shift_out;
    logic               last_shift;

    // Per-digit +3 correction applied in parallel before each shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit    (bcd_sr[g*DIGIT_W +: DIGIT_W]),
            .adjusted (bcd_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // Shift the corrected {bcd, bin} pair left by one; the bit leaving the
    // top digit feeds overflow detection.
    always_comb begin
        shifted    = {bcd_adj, bin_sr, 1'b0};
        shift_out  = shifted[SH_W-1];
        bcd_nxt    = shifted[SH_W-2 -: BCD_W];
        bin_nxt    = shifted[BIN_W-1:0];
        last_shift = (count == CNT_W'(BIN_W - 1));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: accept start in IDLE, return after the last shift.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)      state_nxt = SHIFT;
            SHIFT:   if (last_shift) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == SHIFT);

    // Datapath: capture on accept, shift while busy, load results on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_sr     <= '0;
            bcd_sr     <= '0;
            count      <= '0;
            ovf_sticky <= 1'b0;
            bcd_out    <= '0;
            overflow   <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_sr     <= bin_in;
                        bcd_sr     <= '0;
                        count      <= '0;
                        ovf_sticky <= 1'b0;
                    end
                end
                SHIFT: begin
                    bin_sr     <= bin_nxt;
                    bcd_sr     <= bcd_nxt;
                    count      <= count + CNT_W'(1);
                    ovf_sticky <= ovf_sticky | shift_out;
                    if (last_shift) begin
                        bcd_out  <= bcd_nxt;
                        overflow <= ovf_sticky | shift_out;
                        done     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] blank_nxt;

    // Digit i (i>=1) is blanked when it and every digit above it are zero;
    // the units digit always shows.
    always_comb begin
        logic zero_above;
        blank_nxt  = '0;
        zero_above = 1'b1;
        for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
            zero_above   = zero_above & (bcd_nxt[i*DIGIT_W +: DIGIT_W] == '0);
            blank_nxt[i] = zero_above;
        end
    end

    // Blank mask registered alongside bcd_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_mask <= '0;
        end else if (state == SHIFT && last_shift) begin
            blank_mask <= blank_nxt;
        end
    end
`else
    assign blank_mask = '0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: a 10-bit/4-digit instance and an
// 8-bit/2-digit instance (overflow cases), table vectors, handshake corner
// sequences and randomized values against an arithmetic reference model.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        start;
    logic [9:0]  bin_in;
    logic        busy, done, overflow;
    logic [15:0] bcd_out;
    logic [3:0]  blank_mask;

    logic        start_b;
    logic [7:0]  bin_b;
    logic        busy_b, done_b, ovf_b;
    logic [7:0]  bcd_b;
    logic [1:0]  blank_b;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.BIN_W(10), .DIGITS(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bin_in     (bin_in),
        .busy       (busy),
        .done       (done),
        .bcd_out    (bcd_out),
        .overflow   (overflow),
        .blank_mask (blank_mask)
    );

    bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_b),
        .bin_in     (bin_b),
        .busy       (busy_b),
        .done       (done_b),
        .bcd_out    (bcd_b),
        .overflow   (ovf_b),
        .blank_mask (blank_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: decimal digits of v mod 10^digits; leading-zero digits from magnitude.
    function automatic void model(input int unsigned v, input int unsigned digits,
                                  output logic [31:0] bcd, output logic ovf,
                                  output logic [31:0] blank);
        int unsigned lim = 1;
        int unsigned r;
        int unsigned p = 1;
        for (int unsigned i = 0; i < digits; i++) lim = lim * 10;
        ovf   = (v >= lim);
        r     = v % lim;
        bcd   = '0;
        blank = '0;
        for (int unsigned i = 0; i < digits; i++) begin
            bcd      = bcd | (32'((r / p) % 10) << (4 * i));
            blank[i] = (i >= 1) && (r < p);
            p        = p * 10;
        end
`ifndef BIN2BCD_BLANK_EN
        blank = '0;
`endif
    endfunction

    task automatic conv_a(input int unsigned v, output logic [15:0] r_bcd, output logic r_ovf,
                          output logic [3:0] r_blank, output int lat, output int busy_n);
        @(negedge clk);
        start  = 1'b1;
        bin_in = 10'(v);
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        lat    = 0;
        busy_n = 0;
        while (!done && lat < 50) begin
            if (busy) busy_n++;
            @(negedge clk);
            lat++;
        end
        r_bcd   = bcd_out;
        r_ovf   = overflow;
        r_blank = blank_mask;
        check("busy_low_at_done", 32'(busy), 32'd0);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
    endtask

    task automatic conv_b(input int unsigned v, output logic [7:0] r_bcd, output logic r_ovf,
                          output int lat);
        @(negedge clk);
        start_b = 1'b1;
        bin_b   = 8'(v);
        @(posedge clk);
        @(negedge clk);
        start_b = 1'b0;
        lat     = 0;
        while (!done_b && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        r_bcd = bcd_b;
        r_ovf = ovf_b;
    endtask

    typedef struct {
        int unsigned value;
        logic [15:0] bcd;
        logic        ovf;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [15:0] g_bcd;
        logic        g_ovf;
        logic [3:0]  g_blank;
        logic [7:0]  gb_bcd;
        logic        gb_ovf;
        logic [31:0] e_bcd, e_blank;
        logic        e_ovf;
        logic [15:0] first_bcd;
        int          lat, busy_n, n, m, pulses, done_at;
        int unsigned v;

        vecs[0] = '{1023, 16'h1023, 1'b0};
        vecs[1] = '{0,    16'h0000, 1'b0};
        vecs[2] = '{999,  16'h0999, 1'b0};
        vecs[3] = '{512,  16'h0512, 1'b0};
        vecs[4] = '{1000, 16'h1000, 1'b0};
        vecs[5] = '{9,    16'h0009, 1'b0};
        vecs[6] = '{10,   16'h0010, 1'b0};
        vecs[7] = '{555,  16'h0555, 1'b0};

        rst_n   = 1'b0;
        start   = 1'b0;
        bin_in  = '0;
        start_b = 1'b0;
        bin_b   = '0;
        #12;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_bcd", 32'(bcd_out), 32'd0);
        check("reset_ovf", 32'(overflow), 32'd0);
        check("reset_blank", 32'(blank_mask), 32'd0);
        check("reset_b_bcd", 32'(bcd_b), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table vectors on the 10-bit/4-digit instance.
        for (int i = 0; i < 8; i++) begin
            conv_a(vecs[i].value, g_bcd, g_ovf, g_blank, lat, busy_n);
            model(vecs[i].value, 4, e_bcd, e_ovf, e_blank);
            check($sformatf("tbl%0d_bcd", i), 32'(g_bcd), 32'(vecs[i].bcd));
            check($sformatf("tbl%0d_ovf", i), 32'(g_ovf), 32'(vecs[i].ovf));
            check($sformatf("tbl%0d_blank", i), 32'(g_blank), e_blank);
            check($sformatf("tbl%0d_latency", i), lat, 10);
            check($sformatf("tbl%0d_busy_cycles", i), busy_n, 10);
        end

        // Leading-zero blanking for specific values.
        conv_a(7, g_bcd, g_ovf, g_blank, lat, busy_n);
`ifdef BIN2BCD_BLANK_EN
        check("blank_7", 32'(g_blank), 32'b1110);
`else
        check("blank_7", 32'(g_blank), 32'b0000);
`endif
        conv_a(0, g_bcd, g_ovf, g_blank, lat, busy_n);
`ifdef BIN2BCD_BLANK_EN
        check("blank_0", 32'(g_blank), 32'b1110);
`else
        check("blank_0", 32'(g_blank), 32'b0000);
`endif
        conv_a(1000, g_bcd, g_ovf, g_blank, lat, busy_n);
        check("blank_1000", 32'(g_blank), 32'b0000);

        // Back-to-back: start held through the done cycle.
        @(negedge clk);
        start  = 1'b1;
        bin_in = 10'd0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 50);
        first_bcd = bcd_out;
        check("b2b_first_latency", n, 11);
        check("b2b_first_bcd", 32'(first_bcd), 32'h0000);
        bin_in = 10'd999;
        m = 0;
        do begin
            @(negedge clk);
            m++;
            if (m == 1) start = 1'b0;
        end while (!done && m < 50);
        check("b2b_interval", m, 11);
        check("b2b_second_bcd", 32'(bcd_out), 32'h0999);

        // Start during SHIFT is ignored; bin_in changes have no effect.
        @(negedge clk);
        start  = 1'b1;
        bin_in = 10'd512;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        pulses  = 0;
        done_at = -1;
        for (int i = 1; i <= 28; i++) begin
            @(negedge clk);
            if (i == 3) begin
                start  = 1'b1;
                bin_in = 10'd7;
            end
            if (i == 4) start = 1'b0;
            if (done) begin
                pulses++;
                if (done_at < 0) begin
                    done_at = i;
                    g_bcd   = bcd_out;
                end
            end
        end
        check("ignored_start_pulses", pulses, 1);
        check("ignored_start_done_at", done_at, 10);
        check("ignored_start_bcd", 32'(g_bcd), 32'h0512);

        // Asynchronous reset mid-conversion.
        @(negedge clk);
        start  = 1'b1;
        bin_in = 10'd1000;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_bcd", 32'(bcd_out), 32'd0);
        check("midrst_ovf", 32'(overflow), 32'd0);
        check("midrst_blank", 32'(blank_mask), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        conv_a(42, g_bcd, g_ovf, g_blank, lat, busy_n);
        check("post_rst_bcd", 32'(g_bcd), 32'h0042);
        check("post_rst_latency", lat, 10);
        check("post_rst_busy_cycles", busy_n, 10);

        // 8-bit/2-digit instance: overflow behaviour.
        conv_b(255, gb_bcd, gb_ovf, lat);
        check("b255_bcd", 32'(gb_bcd), 32'h55);
        check("b255_ovf", 32'(gb_ovf), 32'd1);
        check("b255_latency", lat, 8);
        conv_b(99, gb_bcd, gb_ovf, lat);
        check("b99_bcd", 32'(gb_bcd), 32'h99);
        check("b99_ovf", 32'(gb_ovf), 32'd0);

        // Randomized values against the reference model.
        for (int i = 0; i < 20; i++) begin
            v = $urandom_range(1023, 0);
            conv_a(v, g_bcd, g_ovf, g_blank, lat, busy_n);
            model(v, 4, e_bcd, e_ovf, e_blank);
            check($sformatf("rnd_a_bcd(%0d)", v), 32'(g_bcd), e_bcd);
            check($sformatf("rnd_a_blank(%0d)", v), 32'(g_blank), e_blank);
        end
        for (int i = 0; i < 20; i++) begin
            v = $urandom_range(255, 0);
            conv_b(v, gb_bcd, gb_ovf, lat);
            model(v, 2, e_bcd, e_ovf, e_blank);
            check($sformatf("rnd_b_bcd(%0d)", v), 32'(gb_bcd), e_bcd);
            check($sformatf("rnd_b_ovf(%0d)", v), 32'(gb_ovf), 32'(e_ovf));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
